// File: rtl/nanov_spi_arbiter.sv
// SPI flash arbiter for nanoV: shares one SPI device between a continuous
// instruction stream and byte/half/word load-store accesses.
module nanov_spi_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        fetch_start,
  input  logic [23:0] fetch_addr,
  output logic [31:0] fetch_data,
  output logic        fetch_valid,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [1:0]  data_size,
  input  logic [23:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        spi_select,
  output logic        spi_clk_enable,
  output logic        spi_out,
  input  logic        spi_data_in
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_XFER  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_DESEL = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] fetch_addr_q, fetch_addr_d;
  logic        fetch_active_q, fetch_active_d;
  logic        is_data_q, is_data_d;
  logic        we_q, we_d;
  logic [4:0]  last_q, last_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        data_ack_q, data_ack_d;
  logic [31:0] fetch_data_q, fetch_data_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic [23:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rx_q, rx_d;

  logic [31:0] rx_next;
  logic [4:0]  bit_idx;
  logic [4:0]  addr_idx;
  logic [7:0]  cmd_byte;
  logic        arb;
  logic        fetch_abort;

  // Byte k of a transfer lands in bits [8k+7:8k], each byte arriving MSB first.
  assign bit_idx  = {bit_cnt_q[4:3], ~bit_cnt_q[2:0]};
  assign addr_idx = 5'd23 - bit_cnt_q;
  assign cmd_byte = {6'b000000, 1'b1, ~(is_data_q & we_q)};

  always_comb begin
    rx_next          = rx_q;
    rx_next[bit_idx] = spi_data_in;
  end

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    fetch_addr_d   = fetch_addr_q;
    fetch_active_d = fetch_active_q;
    is_data_d      = is_data_q;
    we_d           = we_q;
    last_d         = last_q;
    cmd_addr_d     = cmd_addr_q;
    wdata_d        = wdata_q;
    rx_d           = rx_q;
    fetch_data_d   = fetch_data_q;
    data_rdata_d   = data_rdata_q;
    fetch_valid_d  = 1'b0;
    data_ack_d     = 1'b0;
    arb            = 1'b0;
    fetch_abort    = fetch_start & ~is_data_q;

    case (state_q)
      S_IDLE: arb = 1'b1;
      S_CMD: begin
        if (fetch_abort) begin
          state_d = S_DESEL;
        end else if (bit_cnt_q == 5'd7) begin
          state_d   = S_ADDR;
          bit_cnt_d = 5'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      S_ADDR: begin
        if (fetch_abort) begin
          state_d = S_DESEL;
        end else if (bit_cnt_q == 5'd23) begin
          state_d   = S_XFER;
          bit_cnt_d = 5'd0;
          rx_d      = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      S_XFER: begin
        rx_d = rx_next;
        if (fetch_abort) begin
          state_d = S_DESEL;
        end else if (is_data_q) begin
          if (bit_cnt_q == last_q) begin
            state_d      = S_DESEL;
            data_ack_d   = 1'b1;
            data_rdata_d = rx_next;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else if (bit_cnt_q == 5'd31) begin
          // Word boundary: publish the word, then decide whether the stream continues.
          fetch_valid_d = 1'b1;
          fetch_data_d  = rx_next;
          fetch_addr_d  = fetch_addr_q + 24'd4;
          bit_cnt_d     = 5'd0;
          if (data_req) begin
            state_d = S_DESEL;
          end else if (!fetch_req) begin
            state_d = S_PAUSE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      S_PAUSE: begin
        if (fetch_abort || data_req) begin
          state_d = S_DESEL;
        end else if (fetch_req) begin
          state_d = S_XFER;
        end
      end
      S_DESEL: begin
        if (is_data_q) begin
          state_d = S_IDLE;
        end else begin
          arb = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shared by IDLE and post-fetch DESEL: data wins, otherwise (re)start the stream.
    if (arb) begin
      bit_cnt_d = 5'd0;
      state_d   = S_IDLE;
      if (data_req) begin
        state_d    = S_CMD;
        is_data_d  = 1'b1;
        we_d       = data_we;
        cmd_addr_d = data_addr;
        wdata_d    = data_wdata;
        case (data_size)
          2'd0:    last_d = 5'd7;
          2'd1:    last_d = 5'd15;
          default: last_d = 5'd31;
        endcase
      end else if (fetch_start || (fetch_active_q && fetch_req)) begin
        state_d    = S_CMD;
        is_data_d  = 1'b0;
        cmd_addr_d = fetch_start ? fetch_addr : fetch_addr_q;
      end
    end

    if (fetch_start) begin
      fetch_addr_d   = fetch_addr;
      fetch_active_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= 5'd0;
      fetch_addr_q   <= 24'd0;
      fetch_active_q <= 1'b0;
      is_data_q      <= 1'b0;
      we_q           <= 1'b0;
      last_q         <= 5'd0;
      fetch_valid_q  <= 1'b0;
      data_ack_q     <= 1'b0;
      fetch_data_q   <= 32'd0;
      data_rdata_q   <= 32'd0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      fetch_addr_q   <= fetch_addr_d;
      fetch_active_q <= fetch_active_d;
      is_data_q      <= is_data_d;
      we_q           <= we_d;
      last_q         <= last_d;
      fetch_valid_q  <= fetch_valid_d;
      data_ack_q     <= data_ack_d;
      fetch_data_q   <= fetch_data_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    cmd_addr_q <= cmd_addr_d;
    wdata_q    <= wdata_d;
    rx_q       <= rx_d;
  end

  always_comb begin
    spi_out = 1'b0;
    case (state_q)
      S_CMD:   spi_out = cmd_byte[~bit_cnt_q[2:0]];
      S_ADDR:  spi_out = cmd_addr_q[addr_idx];
      S_XFER:  spi_out = is_data_q & we_q & wdata_q[bit_idx];
      default: spi_out = 1'b0;
    endcase
  end

  assign spi_select     = ~((state_q == S_CMD) || (state_q == S_ADDR) ||
                            (state_q == S_XFER) || (state_q == S_PAUSE));
  assign spi_clk_enable = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_XFER);
  assign fetch_valid    = fetch_valid_q;
  assign fetch_data     = fetch_data_q;
  assign data_ack       = data_ack_q;
  assign data_rdata     = data_rdata_q;

endmodule

// File: tb/tb_nanov_spi_arbiter.sv
// Directed bench for nanov_spi_arbiter with a behavioural SPI flash model.
module tb_nanov_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic        fetch_start = 1'b0;
  logic [23:0] fetch_addr = 24'd0;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [23:0] data_addr = 24'd0;
  logic [31:0] data_wdata = 32'd0;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        spi_select;
  logic        spi_clk_enable;
  logic        spi_out;
  logic        spi_data_in = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cs_low_cnt = 0;
  int cs_high_cnt = 0;
  int pause_cnt = 0;
  int ack_cnt = 0;

  nanov_spi_arbiter dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_start(fetch_start),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .data_req(data_req), .data_we(data_we), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_ack(data_ack), .spi_select(spi_select), .spi_clk_enable(spi_clk_enable),
    .spi_out(spi_out), .spi_data_in(spi_data_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!spi_select) cs_low_cnt <= cs_low_cnt + 1;
    else cs_high_cnt <= cs_high_cnt + 1;
    if (!spi_select && !spi_clk_enable) pause_cnt <= pause_cnt + 1;
    if (data_ack) ack_cnt <= ack_cnt + 1;
  end

  // Flash model: unwritten bytes follow a fixed pattern, with one known word at 0x100.
  logic [7:0]  mem [int];
  logic [7:0]  log_cmd [$];
  logic [23:0] log_addr [$];
  int          m_cnt = 0;
  int          m_j;
  logic [7:0]  m_cmd = 8'd0;
  logic [7:0]  m_byte = 8'd0;
  logic [7:0]  m_b;
  logic [23:0] m_addr = 24'd0;
  logic [23:0] m_ba;
  logic        m_write = 1'b0;

  function automatic logic [7:0] rd(input logic [23:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    if (a == 24'h000100) return 8'h13;
    if (a >= 24'h000101 && a <= 24'h000103) return 8'h00;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    return {rd(a + 24'd3), rd(a + 24'd2), rd(a + 24'd1), rd(a)};
  endfunction

  always @(negedge clk) begin
    if (spi_select) begin
      m_cnt = 0;
      spi_data_in = 1'b0;
    end else if (spi_clk_enable) begin
      if (m_cnt < 32) begin
        spi_data_in = 1'b0;
        if (m_cnt < 8) m_cmd = {m_cmd[6:0], spi_out};
        else m_addr = {m_addr[22:0], spi_out};
        if (m_cnt == 31) begin
          log_cmd.push_back(m_cmd);
          log_addr.push_back(m_addr);
          m_write = (m_cmd == 8'h02);
        end
      end else begin
        m_j  = m_cnt - 32;
        m_ba = m_addr + 24'(m_j / 8);
        if (m_write) begin
          spi_data_in = 1'b0;
          m_byte = {m_byte[6:0], spi_out};
          if (m_j % 8 == 7) mem[int'(m_ba)] = m_byte;
        end else begin
          m_b = rd(m_ba);
          spi_data_in = m_b[3'(7 - m_j % 8)];
        end
      end
      m_cnt = m_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"}, {31'd0, spi_select}, 32'd1);
    check({tag, "_sck"}, {31'd0, spi_clk_enable}, 32'd0);
    check({tag, "_mosi"}, {31'd0, spi_out}, 32'd0);
    check({tag, "_fvalid"}, {31'd0, fetch_valid}, 32'd0);
    check({tag, "_ack"}, {31'd0, data_ack}, 32'd0);
    check({tag, "_fdata"}, fetch_data, 32'd0);
    check({tag, "_rdata"}, data_rdata, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; fetch_start = 1'b0; data_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output logic [31:0] d, output int c);
    logic seen;
    seen = 1'b0; d = 32'd0; c = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (fetch_valid) begin seen = 1'b1; d = fetch_data; c = cyc; end
    end
    check({tag, "_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_ack(input string tag, output logic [31:0] d, output int c, output logic sel);
    logic seen;
    seen = 1'b0; d = 32'd0; c = 0; sel = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (data_ack) begin seen = 1'b1; d = data_rdata; c = cyc; sel = spi_select; end
    end
    data_req = 1'b0;
    check({tag, "_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic do_data(input string tag, input logic we, input logic [1:0] sz,
                         input logic [23:0] a, input logic [31:0] wd,
                         input int exp_lat, input logic [31:0] exp_rd);
    int t0, base, c, nl;
    logic [31:0] d;
    logic sel;
    @(posedge clk); #1;
    data_req = 1'b1; data_we = we; data_size = sz; data_addr = a; data_wdata = wd;
    t0 = cyc; base = cs_low_cnt; nl = log_cmd.size();
    wait_ack(tag, d, c, sel);
    check({tag, "_lat"}, c - t0, exp_lat);
    check({tag, "_cs_low"}, cs_low_cnt - base, exp_lat - 1);
    check({tag, "_sel_at_ack"}, {31'd0, sel}, 32'd1);
    check({tag, "_ncmd"}, log_cmd.size() - nl, 1);
    check({tag, "_cmd"}, {24'd0, log_cmd[log_cmd.size() - 1]}, we ? 32'h02 : 32'h03);
    check({tag, "_addr"}, {8'd0, log_addr[log_addr.size() - 1]}, {8'd0, a});
    if (!we) check({tag, "_rdata"}, d, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int c, c2, c3, t0, base, base2, nl;
    logic sel;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst0");
    rst = 1'b0;
    fetch_req = 1'b1;

    // Fetch stream from 0x100, then a 10-clk pause at a word boundary
    @(posedge clk); #1;
    fetch_start = 1'b1; fetch_addr = 24'h000100; t0 = cyc;
    @(posedge clk); #1 fetch_start = 1'b0;
    wait_valid("w0", d, c);
    check("w0_lat", c - t0, 65);
    check("w0_data", d, 32'h00000013);
    check("w0_cmd", {24'd0, log_cmd[0]}, 32'h03);
    check("w0_addr", {8'd0, log_addr[0]}, 32'h000100);
    wait_valid("w1", d, c2);
    check("w1_gap", c2 - c, 32);
    check("w1_data", d, exp_word(24'h000104));
    @(posedge clk); #1;
    fetch_req = 1'b0; base = pause_cnt;
    wait_valid("w2", d, c3);
    check("w2_gap", c3 - c2, 32);
    check("w2_data", d, exp_word(24'h000108));
    check("pause_sel", {31'd0, spi_select}, 32'd0);
    check("pause_sck", {31'd0, spi_clk_enable}, 32'd0);
    repeat (9) @(posedge clk);
    #1 fetch_req = 1'b1;
    wait_valid("w3", d, c);
    check("w3_gap", c - c3, 42);
    check("w3_data", d, exp_word(24'h00010C));
    check("pause_len", pause_cnt - base, 10);
    check("pause_no_cmd", log_cmd.size(), 1);

    // Data accesses from IDLE
    do_reset();
    do_data("wr_byte", 1'b1, 2'd0, 24'h001234, 32'h000000A5, 41, 32'd0);
    check("wr_byte_mem", {24'd0, rd(24'h001234)}, 32'h000000A5);
    do_data("rd_half", 1'b0, 2'd1, 24'h001234, 32'd0, 49, 32'h00007DA5);
    do_data("rd_word3", 1'b0, 2'd3, 24'h001234, 32'd0, 65, 32'h7F7E7DA5);

    // Data request arriving mid-word during a fetch
    do_reset();
    nl = log_cmd.size();
    @(posedge clk); #1;
    fetch_start = 1'b1; fetch_addr = 24'h000200;
    @(posedge clk); #1 fetch_start = 1'b0;
    repeat (38) @(posedge clk);
    #1;
    data_req = 1'b1; data_we = 1'b1; data_size = 2'd2;
    data_addr = 24'h003000; data_wdata = 32'hDEADBEEF;
    wait_valid("mix_w0", d, c);
    check("mix_w0_data", d, exp_word(24'h000200));
    wait_ack("mix_ack", d, c, sel);
    check("mix_ack_sel", {31'd0, sel}, 32'd1);
    wait_valid("mix_w1", d, c);
    check("mix_w1_data", d, exp_word(24'h000204));
    check("mix_ncmd", log_cmd.size() - nl, 3);
    check("mix_cmd1", {24'd0, log_cmd[nl + 1]}, 32'h02);
    check("mix_addr1", {8'd0, log_addr[nl + 1]}, 32'h003000);
    check("mix_cmd2", {24'd0, log_cmd[nl + 2]}, 32'h03);
    check("mix_addr2", {8'd0, log_addr[nl + 2]}, 32'h000204);
    check("mix_mem", exp_word(24'h003000), 32'hDEADBEEF);

    // fetch_start 12 bits into a word aborts it
    do_reset();
    nl = log_cmd.size();
    @(posedge clk); #1;
    fetch_start = 1'b1; fetch_addr = 24'h000400;
    @(posedge clk); #1 fetch_start = 1'b0;
    repeat (43) @(posedge clk);
    #1;
    fetch_start = 1'b1; fetch_addr = 24'h000500; t0 = cyc; base = cs_high_cnt;
    @(posedge clk); #1 fetch_start = 1'b0;
    wait_valid("abort_w", d, c);
    check("abort_lat", c - t0, 66);
    check("abort_data", d, exp_word(24'h000500));
    check("abort_desel", cs_high_cnt - base, 1);
    check("abort_ncmd", log_cmd.size() - nl, 2);
    check("abort_cmd", {24'd0, log_cmd[nl + 1]}, 32'h03);
    check("abort_addr", {8'd0, log_addr[nl + 1]}, 32'h000500);

    // Reset in the middle of a word write
    do_reset();
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b1; data_size = 2'd2;
    data_addr = 24'h006000; data_wdata = 32'h12345678; base = ack_cnt;
    repeat (45) @(posedge clk);
    #1;
    rst = 1'b1; data_req = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; base2 = cs_low_cnt;
    repeat (60) @(posedge clk);
    #1;
    check("rst_mid_no_ack", ack_cnt - base, 0);
    check("rst_mid_idle", cs_low_cnt - base2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nanov_spi_arbiter.md
NANOV_SPI_ARBITER -- requirements
Module: nanoV_spi_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock for all state; rst input 1, asynchronous active-high reset.
REQ-002 fetch_req  input  1  instruction stream wanted; low at a word boundary pauses the stream.
REQ-003 fetch_start  input  1  single-cycle pulse: (re)start the instruction stream at fetch_addr.
REQ-004 fetch_addr  input  24  byte address of the stream start, sampled on fetch_start.
REQ-005 fetch_data  output  32  last complete instruction word, little-endian.
REQ-006 fetch_valid  output  1  single-cycle pulse: fetch_data updated.
REQ-007 data_req  input  1  load/store request, held until data_ack.
REQ-008 data_we  input  1  1 = write, 0 = read; sampled with data_req.
REQ-009 data_size  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-010 data_addr  input  24  byte address of the data access.
REQ-011 data_wdata  input  32  store data; the low bytes are used first.
REQ-012 data_rdata  output  32  load data, zero-extended, valid with data_ack.
REQ-013 data_ack  output  1  single-cycle pulse: the data access is complete.
REQ-014 spi_select  output  1  SPI chip select, active low.
REQ-015 spi_clk_enable  output  1  SPI clock gate; SCK = clk while high.
REQ-016 spi_out  output  1  MOSI.
REQ-017 spi_data_in  input  1  MISO.

Function
REQ-018 States SHALL be: IDLE, CMD (8 bits), ADDR (24 bits), XFER (8 bits per byte), PAUSE, DESEL; a 5-bit bit counter sequences CMD/ADDR/XFER.
REQ-019 CMD SHALL send 0x03 (read) or 0x02 (write), then ADDR SHALL send 24 address bits; both are sent MSB-first, one bit per clk.
REQ-020 In XFER, bytes SHALL go in ascending address order, each MSB-first; spi_data_in is sampled on the same rising edge at which the bit is shifted, with zero turnaround.
REQ-021 spi_select SHALL be low exactly in CMD/ADDR/XFER/PAUSE; spi_clk_enable SHALL be high exactly in CMD/ADDR/XFER; spi_out SHALL be 0 outside CMD/ADDR/write-XFER.
REQ-022 IDLE: a pending data_req wins over a pending fetch; the transition to CMD SHALL take effect on the next clk.
REQ-023 A fetch stream SHALL stay in XFER continuously; fetch_valid pulses one clk after each 32nd data bit, and the internal fetch address increments by 4 (mod 2^24, wrapping 0xFFFFFC to 0x000000).
REQ-024 Latency from fetch_start in IDLE SHALL be: first fetch_valid 65 clks later; following words every 32 clks.
REQ-025 At a fetch word boundary with data_req high, the arbiter SHALL go to DESEL (1 clk, CS high), serve the data access, then go DESEL, then restart the fetch at the saved next address with a new command.
REQ-026 At a fetch word boundary with fetch_req low and no data_req, the arbiter SHALL enter PAUSE; the stream resumes without a new command when fetch_req rises, and goes to DESEL if data_req rises.
REQ-027 fetch_start SHALL abort any fetch or PAUSE immediately (no fetch_valid for a partial word), go to DESEL, then restart at the new address.
REQ-028 fetch_start during a data access SHALL only latch the address; the data access completes first.
REQ-029 A data access SHALL transfer 1, 2 or 4 bytes; data_ack pulses in the first DESEL clk after the last bit; CS is low for 40, 48 or 64 clks.
REQ-030 A data access SHALL always be followed by DESEL, then IDLE.

Reset
REQ-031 rst SHALL force, asynchronously: IDLE, spi_select=1, spi_clk_enable=0, spi_out=0, fetch_valid=0, data_ack=0, fetch_data=0, data_rdata=0, fetch address=0, bit counter=0.
REQ-032 rst asserted mid-transfer SHALL abandon the transfer with no ack or valid; after release the arbiter waits for a new fetch_start or data_req.

Verification
REQ-033 fetch_start with fetch_addr=0x000100 and a model holding 0x00000013 there -> bits 0x03,0x000100 on spi_out; fetch_valid 65 clks later with fetch_data=0x00000013; the next word 32 clks after that.
REQ-034 data_req, data_we=1, data_size=0, data_addr=0x001234, data_wdata=0x000000A5 while IDLE -> CS low 40 clks sending 0x02,0x001234,0xA5; data_ack in the next clk with CS high.
REQ-035 data_req asserted mid-word during a fetch from 0x000200 -> the word at 0x000200 completes, then DESEL and the data access, then a new 0x03 command to 0x000204.
REQ-036 fetch_req dropped for 10 clks at a word boundary -> spi_select low, spi_clk_enable low for 10 clks, no new command, stream resumes correctly.
REQ-037 fetch_start during a fetch, 12 bits into a word -> no fetch_valid, 1 DESEL clk, command to the new address; rst asserted mid-write -> all outputs at reset values immediately and no data_ack.
